imem_fetch_ctrl: RTL and testbench
==================================

// Module: imem_fetch_ctrl
// PURPOSE
//  Sequences the word-addressed instruction memory (combinational read, 2^ADDR_W x 32b).
//  After reset it loads a program into the memory through a streaming loader port,
//  then runs the fetch loop: it holds the PC, reads one word per cycle and presents it
//  to decode through a registered valid/ready stage. Supports branch redirect and halt.
// PARAMETERS
//  ADDR_W         8        memory word-index width (256 words)
//  RESET_PC       32'h0    PC after reset and after load completes
//  LOAD_ON_RESET  1        1: reset enters LOAD; 0: reset enters RUN directly
// PORTS
//  clk             in   1       clock, all state on rising edge
//  reset           in   1       asynchronous, active-low reset
//  ld_valid        in   1       loader word valid
//  ld_ready        out  1       loader word accepted (1 only in LOAD)
//  ld_data         in   32      instruction word to write
//  ld_last         in   1       marks final loader word
//  mem_addr        out  ADDR_W  memory word index
//  mem_we          out  1       memory write enable
//  mem_wdata       out  32      memory write data (= ld_data)
//  mem_rdata       in   32      memory read data, same cycle as mem_addr
//  redirect_valid  in   1       branch/jump taken this cycle
//  redirect_pc     in   32      byte address of target
//  halt_req        in   1       stop fetching (level or pulse)
//  inst_valid      out  1       inst_data/inst_pc valid to decode
//  inst_ready      in   1       decode accepts
//  inst_data       out  32      fetched instruction
//  inst_pc         out  32      byte address of inst_data
//  busy_loading    out  1       1 while in LOAD
//  halted          out  1       1 while in HALT
// BEHAVIOUR
//  Reset (reset=0, async): state=LOAD if LOAD_ON_RESET else RUN; pc=RESET_PC; ld_cnt=0;
//   inst_valid=0, inst_data=0, inst_pc=0; halted=0. Combinational outputs follow state.
//  States: LOAD -> RUN -> HALT; HALT -> RUN on redirect_valid only.
//  LOAD: ld_ready=1, mem_addr=ld_cnt, mem_we=ld_valid, mem_wdata=ld_data.
//   Each ld_valid cycle writes one word, ld_cnt+=1. ld_last accepted, or the write to index
//   2^ADDR_W-1 -> RUN next cycle with pc=RESET_PC. redirect/halt_req ignored in LOAD.
//  RUN: mem_we=0, mem_addr=pc[ADDR_W+1:2] (upper PC bits ignored -> address wraps).
//   Advance when !inst_valid || inst_ready: capture inst_data=mem_rdata, inst_pc=pc,
//   inst_valid=1, pc+=4 (32-bit wrap). Otherwise hold all outputs and pc (stall).
//   First inst_valid = 1 cycle after entering RUN (one-cycle fetch latency).
//  Redirect (RUN, priority over advance): pc=redirect_pc & ~32'h3, inst_valid=0 next cycle;
//   no old-path word is presented after the redirect cycle; target valid 2 cycles after.
//   The word presented in the redirect cycle counts as accepted only if inst_ready=1.
//  halt_req in RUN: no new capture; once inst_valid=0 (or accepted that cycle) -> HALT.
//   With simultaneous redirect: pc=redirect target, inst_valid=0, -> HALT.
//  HALT: halted=1, inst_valid=0, pc held. redirect_valid -> RUN with pc=redirect target.
//  Reset mid-load or mid-fetch: immediate return to reset state; ld_cnt restarts at 0.
// TESTING
//  T1 load 6 words (E3A00003,E3500000,0A000002,E2400001,EAFFFFFC,E3A0102A), ld_last on
//     6th -> mem[0..5] written in order, busy_loading falls, inst 0 pc=0 2 cycles later.
//  T2 inst_ready=1 continuous -> inst_pc 0,4,8,... one per cycle, inst_data = mem words.
//  T3 inst_ready=0 for 3 cycles at pc=8 -> inst_data/inst_pc held stable, no word skipped.
//  T4 redirect_pc=0x12 while pc=0x10 -> next valid inst_pc=0x10, old 0x14 never shown.
//  T5 halt_req with inst_valid=1, inst_ready=0 -> held until accepted, then halted=1;
//     redirect_pc=0x4 -> resumes, inst_pc=0x4.
//  T6 reset low mid-load after 3 words -> ld_cnt=0, next load writes from mem[0].

Source files
------------

// File: rtl/imem_fetch_ctrl_if.sv
// Bundle of loader, instruction-memory, redirect and decode-side signals for imem_fetch_ctrl.
// master = the fetch controller, slave = the surrounding memory/loader/decode logic.
interface imem_fetch_ctrl_if #(
    parameter int unsigned ADDR_W = 8
);
    logic              ld_valid;
    logic              ld_ready;
    logic [31:0]       ld_data;
    logic              ld_last;

    logic [ADDR_W-1:0] mem_addr;
    logic              mem_we;
    logic [31:0]       mem_wdata;
    logic [31:0]       mem_rdata;

    logic              redirect_valid;
    logic [31:0]       redirect_pc;
    logic              halt_req;

    logic              inst_valid;
    logic              inst_ready;
    logic [31:0]       inst_data;
    logic [31:0]       inst_pc;

    logic              busy_loading;
    logic              halted;

    modport master (
        input  ld_valid, ld_data, ld_last, mem_rdata,
        input  redirect_valid, redirect_pc, halt_req, inst_ready,
        output ld_ready, mem_addr, mem_we, mem_wdata,
        output inst_valid, inst_data, inst_pc, busy_loading, halted
    );

    modport slave (
        output ld_valid, ld_data, ld_last, mem_rdata,
        output redirect_valid, redirect_pc, halt_req, inst_ready,
        input  ld_ready, mem_addr, mem_we, mem_wdata,
        input  inst_valid, inst_data, inst_pc, busy_loading, halted
    );
endinterface

// File: rtl/imem_fetch_ctrl.sv
// Instruction memory sequencer: streams a program into the memory after reset, then
// fetches one word per cycle into a registered valid/ready stage with redirect and halt.
module imem_fetch_ctrl #(
    parameter int unsigned ADDR_W        = 8,
    parameter logic [31:0] RESET_PC      = 32'h0,
    parameter bit          LOAD_ON_RESET = 1'b1
) (
    input  logic              clk,
    input  logic              reset,
    imem_fetch_ctrl_if.master bus
);

    typedef enum logic [1:0] {
        ST_LOAD = 2'd0,
        ST_RUN  = 2'd1,
        ST_HALT = 2'd2
    } state_e;

    localparam state_e            RESET_STATE = LOAD_ON_RESET ? ST_LOAD : ST_RUN;
    localparam logic [ADDR_W-1:0] LAST_IDX    = '1;

    state_e            state_q, state_d;
    logic [31:0]       pc_q, pc_d;
    logic [ADDR_W-1:0] ld_cnt_q, ld_cnt_d;
    logic              inst_valid_q, inst_valid_d;
    logic [31:0]       inst_data_q, inst_data_d;
    logic [31:0]       inst_pc_q, inst_pc_d;

    logic              advance;
    logic [31:0]       redirect_tgt;
    logic              in_load;

    // Next-state and fetch-stage update
    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        ld_cnt_d     = ld_cnt_q;
        inst_valid_d = inst_valid_q;
        inst_data_d  = inst_data_q;
        inst_pc_d    = inst_pc_q;
        advance      = !inst_valid_q || bus.inst_ready;
        redirect_tgt = bus.redirect_pc & ~32'h3;

        case (state_q)
            ST_LOAD: begin
                if (bus.ld_valid) begin
                    ld_cnt_d = ld_cnt_q + ADDR_W'(1);
                    if (bus.ld_last || (ld_cnt_q == LAST_IDX)) begin
                        state_d  = ST_RUN;
                        pc_d     = RESET_PC;
                        ld_cnt_d = '0;
                    end
                end
            end
            ST_RUN: begin
                // Redirect kills the stage; the in-flight word is only consumed if inst_ready.
                if (bus.redirect_valid) begin
                    pc_d         = redirect_tgt;
                    inst_valid_d = 1'b0;
                    if (bus.halt_req) begin
                        state_d = ST_HALT;
                    end
                end else if (bus.halt_req) begin
                    if (advance) begin
                        inst_valid_d = 1'b0;
                        state_d      = ST_HALT;
                    end
                end else if (advance) begin
                    inst_valid_d = 1'b1;
                    inst_data_d  = bus.mem_rdata;
                    inst_pc_d    = pc_q;
                    pc_d         = pc_q + 32'd4;
                end
            end
            ST_HALT: begin
                inst_valid_d = 1'b0;
                if (bus.redirect_valid) begin
                    state_d = ST_RUN;
                    pc_d    = redirect_tgt;
                end
            end
            default: begin
                state_d = RESET_STATE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= RESET_STATE;
            pc_q         <= RESET_PC;
            ld_cnt_q     <= '0;
            inst_valid_q <= 1'b0;
            inst_data_q  <= '0;
            inst_pc_q    <= '0;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            ld_cnt_q     <= ld_cnt_d;
            inst_valid_q <= inst_valid_d;
            inst_data_q  <= inst_data_d;
            inst_pc_q    <= inst_pc_d;
        end
    end

    // Memory port is owned by the loader in LOAD, by the PC otherwise
    assign in_load          = (state_q == ST_LOAD);
    assign bus.ld_ready     = in_load;
    assign bus.mem_we       = in_load && bus.ld_valid;
    assign bus.mem_addr     = in_load ? ld_cnt_q : pc_q[ADDR_W+1:2];
    assign bus.mem_wdata    = bus.ld_data;
    assign bus.inst_valid   = inst_valid_q;
    assign bus.inst_data    = inst_data_q;
    assign bus.inst_pc      = inst_pc_q;
    assign bus.busy_loading = in_load;
    assign bus.halted       = (state_q == ST_HALT);

endmodule

// File: tb/tb_imem_fetch_ctrl.sv
// Self-checking bench for imem_fetch_ctrl: memory array, directed scenarios, random traffic,
// and a per-cycle behavioural model of load/fetch/redirect/halt.
module tb_imem_fetch_ctrl;
    localparam int unsigned ADDR_W = 8;
    localparam int unsigned DEPTH  = 256;
    localparam int M_LOAD = 0;
    localparam int M_RUN  = 1;
    localparam int M_HALT = 2;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    imem_fetch_ctrl_if #(.ADDR_W(ADDR_W)) bus ();

    imem_fetch_ctrl #(
        .ADDR_W(ADDR_W),
        .RESET_PC(32'h0),
        .LOAD_ON_RESET(1'b1)
    ) dut (
        .clk(clk),
        .reset(reset),
        .bus(bus)
    );

    // Instruction memory: combinational read, clocked write
    logic [31:0] mem [DEPTH];
    assign bus.mem_rdata = mem[bus.mem_addr];
    always @(posedge clk) begin
        if (bus.mem_we) mem[bus.mem_addr] <= bus.mem_wdata;
    end

    int errors = 0;
    int checks = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            if (errors <= 40)
                $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Behavioural model: program image plus architectural view of the fetch stage
    logic [31:0] prog [DEPTH];
    int          m_mode;
    int          m_cnt;
    logic [31:0] m_pc;
    bit          m_v;
    logic [31:0] m_ipc;
    logic [31:0] m_idata;

    initial begin : compare
        bit take;
        forever begin
            @(negedge clk);
            if (!reset) begin
                m_mode = M_LOAD; m_cnt = 0; m_pc = 32'h0;
                m_v = 1'b0; m_ipc = 32'h0; m_idata = 32'h0;
                chk("rst_busy",   32'(bus.busy_loading), 32'd1);
                chk("rst_halted", 32'(bus.halted), 32'd0);
                chk("rst_valid",  32'(bus.inst_valid), 32'd0);
                chk("rst_pc",     bus.inst_pc, 32'h0);
                chk("rst_data",   bus.inst_data, 32'h0);
                chk("rst_addr",   32'(bus.mem_addr), 32'd0);
            end else begin
                chk("busy_loading", 32'(bus.busy_loading), 32'(m_mode == M_LOAD));
                chk("ld_ready",     32'(bus.ld_ready), 32'(m_mode == M_LOAD));
                chk("halted",       32'(bus.halted), 32'(m_mode == M_HALT));
                chk("mem_we",       32'(bus.mem_we), 32'((m_mode == M_LOAD) && bus.ld_valid));
                if (m_mode == M_LOAD) begin
                    chk("mem_addr_load", 32'(bus.mem_addr), 32'(m_cnt));
                    if (bus.ld_valid) chk("mem_wdata", bus.mem_wdata, bus.ld_data);
                end else begin
                    chk("mem_addr_fetch", 32'(bus.mem_addr), (m_pc >> 2) % DEPTH);
                end
                chk("inst_valid", 32'(bus.inst_valid), 32'(m_v));
                if (m_v) begin
                    chk("inst_pc",   bus.inst_pc, m_ipc);
                    chk("inst_data", bus.inst_data, m_idata);
                end

                case (m_mode)
                    M_LOAD: begin
                        if (bus.ld_valid) begin
                            prog[m_cnt] = bus.ld_data;
                            if (bus.ld_last || m_cnt == DEPTH - 1) begin
                                m_mode = M_RUN; m_pc = 32'h0; m_cnt = 0;
                            end else begin
                                m_cnt++;
                            end
                        end
                    end
                    M_RUN: begin
                        take = !m_v || bus.inst_ready;
                        if (bus.redirect_valid) begin
                            m_pc = {bus.redirect_pc[31:2], 2'b00};
                            m_v  = 1'b0;
                            if (bus.halt_req) m_mode = M_HALT;
                        end else if (bus.halt_req) begin
                            if (take) begin m_v = 1'b0; m_mode = M_HALT; end
                        end else if (take) begin
                            m_v     = 1'b1;
                            m_ipc   = m_pc;
                            m_idata = prog[(m_pc >> 2) % DEPTH];
                            m_pc    = m_pc + 32'd4;
                        end
                    end
                    default: begin
                        if (bus.redirect_valid) begin
                            m_pc   = {bus.redirect_pc[31:2], 2'b00};
                            m_mode = M_RUN;
                        end
                    end
                endcase
            end
        end
    end

    logic [31:0] t1w [6] = '{32'hE3A00003, 32'hE3500000, 32'h0A000002,
                             32'hE2400001, 32'hEAFFFFFC, 32'hE3A0102A};

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        bus.ld_valid = 1'b0; bus.ld_data = 32'h0; bus.ld_last = 1'b0;
        bus.redirect_valid = 1'b0; bus.redirect_pc = 32'h0;
        bus.halt_req = 1'b0; bus.inst_ready = 1'b1;
    endtask

    task automatic do_reset(input int n);
        reset = 1'b0;
        repeat (n) cyc();
        reset = 1'b1;
    endtask

    task automatic load_word(input logic [31:0] w, input bit last);
        int gap = $urandom_range(0, 2);
        repeat (gap) begin
            bus.ld_valid = 1'b0; bus.ld_data = $urandom; bus.ld_last = 1'($urandom);
            cyc();
        end
        bus.ld_valid = 1'b1; bus.ld_data = w; bus.ld_last = last;
        cyc();
        bus.ld_valid = 1'b0; bus.ld_last = 1'b0;
    endtask

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
        $fatal(1, "watchdog expired");
    end

    initial begin : stim
        logic [31:0] w0;
        logic [31:0] w;
        int n;
        clear_inputs();
        do_reset(3);

        // Fill all 256 words without ld_last; the last index ends the load
        w0 = 32'h0;
        for (int i = 0; i < int'(DEPTH); i++) begin
            w = $urandom;
            if (i == 0) w0 = w;
            load_word(w, 1'b0);
        end
        chk("full_load_exit", 32'(bus.busy_loading), 32'd0);
        cyc();
        chk("full_first_valid", 32'(bus.inst_valid), 32'd1);
        chk("full_first_data", bus.inst_data, w0);
        repeat (20) begin bus.inst_ready = 1'($urandom); cyc(); end
        bus.inst_ready = 1'b1;

        // Partial load interrupted by reset; the next load must restart at word 0
        do_reset(2);
        for (int i = 0; i < 3; i++) load_word(32'hDEAD0000 + 32'(i), 1'b0);
        chk("t6_midload_busy", 32'(bus.busy_loading), 32'd1);
        do_reset(2);

        for (int i = 0; i < 6; i++) load_word(t1w[i], i == 5);
        chk("t1_busy_fell", 32'(bus.busy_loading), 32'd0);
        chk("t1_not_yet_valid", 32'(bus.inst_valid), 32'd0);
        cyc();
        chk("t1_valid", 32'(bus.inst_valid), 32'd1);
        chk("t1_pc0", bus.inst_pc, 32'h0);
        chk("t1_data0", bus.inst_data, 32'hE3A00003);

        cyc();
        chk("t2_pc4", bus.inst_pc, 32'h4);
        chk("t2_data4", bus.inst_data, 32'hE3500000);
        cyc();
        chk("t2_pc8", bus.inst_pc, 32'h8);

        // Stall at pc 8
        bus.inst_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            cyc();
            chk("t3_hold_pc", bus.inst_pc, 32'h8);
            chk("t3_hold_data", bus.inst_data, 32'h0A000002);
        end
        bus.inst_ready = 1'b1;
        cyc();
        chk("t3_next_pc", bus.inst_pc, 32'hC);
        chk("t3_next_data", bus.inst_data, 32'hE2400001);

        // Redirect to 0x12 while the fetch PC is 0x10
        bus.redirect_valid = 1'b1; bus.redirect_pc = 32'h12;
        cyc();
        bus.redirect_valid = 1'b0;
        chk("t4_bubble", 32'(bus.inst_valid), 32'd0);
        cyc();
        chk("t4_valid", 32'(bus.inst_valid), 32'd1);
        chk("t4_pc", bus.inst_pc, 32'h10);
        chk("t4_data", bus.inst_data, 32'hEAFFFFFC);

        // Halt while decode is stalled, then resume at 0x4
        bus.inst_ready = 1'b0; bus.halt_req = 1'b1;
        for (int i = 0; i < 3; i++) begin
            cyc();
            chk("t5_held_valid", 32'(bus.inst_valid), 32'd1);
            chk("t5_held_pc", bus.inst_pc, 32'h10);
            chk("t5_not_halted", 32'(bus.halted), 32'd0);
        end
        bus.inst_ready = 1'b1;
        cyc();
        chk("t5_halted", 32'(bus.halted), 32'd1);
        chk("t5_halt_invalid", 32'(bus.inst_valid), 32'd0);
        bus.halt_req = 1'b0;
        cyc(); cyc();
        chk("t5_still_halted", 32'(bus.halted), 32'd1);
        bus.redirect_valid = 1'b1; bus.redirect_pc = 32'h4;
        cyc();
        bus.redirect_valid = 1'b0;
        chk("t5_resumed", 32'(bus.halted), 32'd0);
        cyc();
        chk("t5_valid", 32'(bus.inst_valid), 32'd1);
        chk("t5_pc", bus.inst_pc, 32'h4);
        chk("t5_data", bus.inst_data, 32'hE3500000);

        // Random traffic, with occasional reset and reload of a short program
        for (int c = 0; c < 3000; c++) begin
            if ($urandom_range(0, 599) == 0) begin
                clear_inputs();
                do_reset(2);
                n = $urandom_range(1, 40);
                for (int k = 0; k < n; k++) load_word($urandom, k == n - 1);
            end
            bus.inst_ready     = ($urandom_range(0, 3) != 0);
            bus.redirect_valid = ($urandom_range(0, 15) == 0);
            case ($urandom_range(0, 3))
                0:       bus.redirect_pc = $urandom;
                1:       bus.redirect_pc = 32'hFFFFFFF0 | 32'($urandom_range(0, 15));
                default: bus.redirect_pc = 32'($urandom_range(0, 1023));
            endcase
            if ($urandom_range(0, 31) == 0) bus.halt_req = ~bus.halt_req;
            bus.ld_valid = 1'($urandom);
            bus.ld_data  = $urandom;
            bus.ld_last  = 1'($urandom);
            cyc();
        end

        clear_inputs();
        repeat (3) cyc();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
